// File: rtl/fft_pkg.sv
// Shared types and helpers for the in-place radix-2 DIT FFT sequencer.
package fft_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_BR_RD_A,
    S_BR_RD_B,
    S_BR_CAP,
    S_BR_WR_A,
    S_BR_WR_B,
    S_RD_A,
    S_RD_B,
    S_CAP_B,
    S_BF_GO,
    S_BF_WAIT,
    S_WR_A,
    S_WR_B,
    S_DONE
  } state_t;

  localparam int unsigned CPLX_W = 32;

  // Samples are packed {re, im}, each Q1.15.
  function automatic logic [15:0] re_of(input logic [CPLX_W-1:0] v);
    return v[31:16];
  endfunction

  function automatic logic [15:0] im_of(input logic [CPLX_W-1:0] v);
    return v[15:0];
  endfunction

  function automatic logic [CPLX_W-1:0] pack_c(input logic [15:0] re, input logic [15:0] im);
    return {re, im};
  endfunction

  // Reverses the low n bits of v; bits above n come out zero.
  function automatic logic [15:0] bitrev(input logic [15:0] v, input int unsigned n);
    logic [15:0] r;
    logic [15:0] x;
    r = '0;
    x = v;
    for (int unsigned b = 0; b < n; b++) begin
      r = {r[14:0], x[0]};
      x = {1'b0, x[15:1]};
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Butterfly operand addressing and twiddle index for stage s, butterfly k.
module fft_addr_gen #(
  parameter int N_LOG2 = 5,
  parameter int SW     = $clog2(N_LOG2)
) (
  input  logic [SW-1:0]     s,
  input  logic [N_LOG2-2:0] k,
  output logic [N_LOG2-1:0] addr_a,
  output logic [N_LOG2-1:0] addr_b,
  output logic [N_LOG2-2:0] tw
);

  logic [N_LOG2-1:0] kx;
  logic [N_LOG2-1:0] half;
  logic [N_LOG2-1:0] j;
  int unsigned       sh;

  always_comb begin
    sh     = 32'(s);
    kx     = {1'b0, k};
    half   = N_LOG2'(1) << sh;
    j      = kx & (half - 1'b1);
    addr_a = ((kx >> sh) << (sh + 1)) + j;
    addr_b = addr_a + half;
    tw     = (N_LOG2-1)'(j << (N_LOG2 - 1 - sh));
  end

endmodule

// File: rtl/fft_sched.sv
// In-place radix-2 DIT FFT sequencer: optional bit-reverse pass, then N_LOG2
// butterfly stages, sharing the dmem port through a req/gnt handshake.
module fft_sched
  import fft_pkg::*;
#(
  parameter int N_LOG2    = 5,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              cfg_bitrev,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bf_start,
  output logic [DATA_W-1:0] bf_a,
  output logic [DATA_W-1:0] bf_b,
  output logic [N_LOG2-2:0] bf_tw,
  input  logic              bf_done,
  input  logic [DATA_W-1:0] bf_ya,
  input  logic [DATA_W-1:0] bf_yb
);

  localparam int SW = $clog2(N_LOG2);

  state_t            state;
  logic [SW-1:0]     s;
  logic [N_LOG2-2:0] k;
  logic [N_LOG2-1:0] i;
  logic [N_LOG2-1:0] r;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] ya;
  logic [DATA_W-1:0] yb;
  logic              cap_a;
  logic              cap_b;
  logic [N_LOG2-1:0] addr_a;
  logic [N_LOG2-1:0] addr_b;
  logic [N_LOG2-2:0] tw;
  logic [N_LOG2-1:0] idx;
  logic              last_k;
  logic              last_s;
  logic              last_i;

  fft_addr_gen #(
    .N_LOG2(N_LOG2),
    .SW    (SW)
  ) u_addr_gen (
    .s     (s),
    .k     (k),
    .addr_a(addr_a),
    .addr_b(addr_b),
    .tw    (tw)
  );

  assign r      = N_LOG2'(bitrev(16'(i), N_LOG2));
  assign last_k = (k == '1);
  assign last_s = (s == SW'(N_LOG2 - 1));
  assign last_i = (i == '1);

  assign bf_a  = op_a;
  assign bf_b  = op_b;
  assign bf_tw = tw;

  // Read data trails its grant by one cycle, so the destination register is
  // chosen at grant time and loaded on the following edge regardless of state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_a <= 1'b0;
      cap_b <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
    end else begin
      cap_a <= mem_req && mem_gnt && !mem_we && (state == S_RD_A || state == S_BR_RD_A);
      cap_b <= mem_req && mem_gnt && !mem_we && (state == S_RD_B || state == S_BR_RD_B);
      if (cap_a) op_a <= mem_rdata;
      if (cap_b) op_b <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      s        <= '0;
      k        <= '0;
      i        <= '0;
      ya       <= '0;
      yb       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bf_start <= 1'b0;
    end else begin
      done     <= 1'b0;
      bf_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            s     <= '0;
            k     <= '0;
            i     <= '0;
            state <= cfg_bitrev ? S_BR_RD_A : S_RD_A;
          end
        end
        S_BR_RD_A: begin
          if (r <= i) begin
            if (last_i) state <= S_RD_A;
            else        i     <= i + 1'b1;
          end else if (mem_gnt) begin
            state <= S_BR_RD_B;
          end
        end
        S_BR_RD_B: if (mem_gnt) state <= S_BR_CAP;
        S_BR_CAP:  state <= S_BR_WR_A;
        S_BR_WR_A: if (mem_gnt) state <= S_BR_WR_B;
        S_BR_WR_B: begin
          if (mem_gnt) begin
            i     <= i + 1'b1;
            state <= S_BR_RD_A;
          end
        end
        S_RD_A: if (mem_gnt) state <= S_RD_B;
        S_RD_B: if (mem_gnt) state <= S_CAP_B;
        S_CAP_B: begin
          bf_start <= 1'b1;
          state    <= S_BF_GO;
        end
        S_BF_GO: state <= S_BF_WAIT;
        S_BF_WAIT: begin
          if (bf_done) begin
            ya    <= bf_ya;
            yb    <= bf_yb;
            state <= S_WR_A;
          end
        end
        S_WR_A: if (mem_gnt) state <= S_WR_B;
        S_WR_B: begin
          if (mem_gnt) begin
            k <= k + 1'b1;
            if (last_k && last_s) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              if (last_k) s <= s + 1'b1;
              state <= S_RD_A;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    idx       = '0;
    mem_wdata = '0;
    case (state)
      S_BR_RD_A: begin
        mem_req = (r > i);
        idx     = i;
      end
      S_BR_RD_B: begin
        mem_req = 1'b1;
        idx     = r;
      end
      S_BR_WR_A: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        idx       = i;
        mem_wdata = op_b;
      end
      S_BR_WR_B: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        idx       = r;
        mem_wdata = op_a;
      end
      S_RD_A: begin
        mem_req = 1'b1;
        idx     = addr_a;
      end
      S_RD_B: begin
        mem_req = 1'b1;
        idx     = addr_b;
      end
      S_WR_A: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        idx       = addr_a;
        mem_wdata = ya;
      end
      S_WR_B: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        idx       = addr_b;
        mem_wdata = yb;
      end
      default: ;
    endcase
    mem_addr = mem_req ? ADDR_W'(BASE_ADDR) + ADDR_W'(idx) : '0;
  end

endmodule
